// File: rtl/nes_joy_pkg.sv
// Shared types and helpers for the NES joypad reader.
package nes_joy_pkg;

  // Reader frame sequencer states
  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT,
    CLK_HI,
    CLK_LO,
    DONE
  } joy_state_t;

  // Button positions in the published vector (same order as the core's joypad model)
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Clock cycles in a duration of 'us' microseconds at 'hz', rounded to nearest
  function automatic int unsigned cycles_from_us(input int unsigned hz, input int unsigned us);
    logic [63:0] prod;
    prod = 64'(hz) * 64'(us) + 64'd500_000;
    return 32'(prod / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/nes_joy_sync.sv
// Two-flop synchronizer for the pad's serial data line.
// Resets to 1 so an idle or disconnected pad reads as "released".
module nes_joy_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_joypad_reader.sv
// NES controller reader: drives latch/shift-clock to an external 4021 pad,
// samples the serial data and publishes an active-high button vector.
module nes_joypad_reader
  import nes_joy_pkg::*;
#(
  parameter int unsigned C_clk_hz    = 21477272,
  parameter int unsigned C_half_us   = 6,
  parameter int unsigned C_latch_us  = 12,
  parameter int unsigned C_poll_hz   = 60,
  parameter int unsigned C_auto_poll = 1,
  parameter int unsigned C_num_bits  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_poll,
  input  logic                  joy_data,
  output logic                  joy_strobe,
  output logic                  joy_clock,
  output logic [C_num_bits-1:0] o_btn,
  output logic                  o_valid,
  output logic                  o_busy
);

  localparam int unsigned C_H    = cycles_from_us(C_clk_hz, C_half_us);
  localparam int unsigned C_L    = cycles_from_us(C_clk_hz, C_latch_us);
  localparam int unsigned C_P    = C_clk_hz / C_poll_hz;
  localparam int unsigned C_TMAX = (C_L > C_H) ? C_L : C_H;
  localparam int unsigned TW     = $clog2(C_TMAX);
  localparam int unsigned PW     = $clog2(C_P);
  localparam int unsigned BW     = (C_num_bits > 1) ? $clog2(C_num_bits) : 1;

  if (C_H < 4 || C_num_bits < 1 || C_L < 1 ||
      C_P <= C_L + C_H + (C_num_bits - 1) * 2 * C_H + 2) begin : g_bad_params
    $error("nes_joypad_reader: timing parameters out of range");
  end

  joy_state_t            state, state_n;
  logic [TW-1:0]         tmr, tmr_n;
  logic [BW-1:0]         bit_idx, bit_n;
  logic [C_num_bits-1:0] sr, sr_n;
  logic                  pending, pend_n;
  logic                  publish;
  logic [PW-1:0]         poll_cnt;
  logic                  poll_wrap;
  logic                  req;
  logic                  data_s;

  nes_joy_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (joy_data),
    .q       (data_s)
  );

  assign poll_wrap = (poll_cnt == PW'(C_P - 1));
  assign req       = i_poll | ((C_auto_poll != 0) & poll_wrap);

  // Free-running poll period counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
    end else if (poll_wrap) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // Frame sequencer state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, phase timer, sampling and pending-request logic
  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    bit_n   = bit_idx;
    sr_n    = sr;
    pend_n  = pending;
    publish = 1'b0;

    if (state != IDLE && req) begin
      pend_n = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (req || pending) begin
          state_n = LATCH;
          tmr_n   = TW'(C_L - 1);
          pend_n  = 1'b0;
        end
      end
      LATCH: begin
        if (tmr == '0) begin
          state_n = WAIT;
          tmr_n   = TW'(C_H - 1);
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      WAIT: begin
        if (tmr == '0) begin
          sr_n[0] = data_s;
          tmr_n   = TW'(C_H - 1);
          bit_n   = BW'(1);
          if (C_num_bits == 1) begin
            state_n = DONE;
            publish = 1'b1;
          end else begin
            state_n = CLK_HI;
          end
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      CLK_HI: begin
        if (tmr == '0) begin
          state_n = CLK_LO;
          tmr_n   = TW'(C_H - 1);
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      CLK_LO: begin
        if (tmr == '0) begin
          sr_n[bit_idx] = data_s;
          tmr_n         = TW'(C_H - 1);
          if (bit_idx == BW'(C_num_bits - 1)) begin
            state_n = DONE;
            publish = 1'b1;
          end else begin
            state_n = CLK_HI;
            bit_n   = bit_idx + 1'b1;
          end
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; outputs are decoded from the next state so
  // they line up with the state they belong to, and the result is published on
  // the edge that enters DONE so o_btn and o_valid change together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmr        <= '0;
      bit_idx    <= '0;
      sr         <= '0;
      pending    <= 1'b0;
      joy_strobe <= 1'b0;
      joy_clock  <= 1'b0;
      o_btn      <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      tmr        <= tmr_n;
      bit_idx    <= bit_n;
      sr         <= sr_n;
      pending    <= pend_n;
      joy_strobe <= (state_n == LATCH);
      joy_clock  <= (state_n == CLK_HI);
      o_valid    <= publish;
      o_busy     <= (state_n != IDLE);
      if (publish) begin
        o_btn <= ~sr_n;
      end
    end
  end

endmodule

// File: tb/tb_nes_joypad_reader.sv
// Bench for nes_joypad_reader: behavioural 4021 pad models, scoreboard of
// expected button vectors, timing and poll-rate checks.
`timescale 1ns/1ps
module tb_nes_joypad_reader;
  import nes_joy_pkg::*;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned NBITS  = 8;
  localparam int          T_H    = (CLK_HZ / 1_000_000) * 6;
  localparam int          T_L    = (CLK_HZ / 1_000_000) * 12;
  localparam int          FRAME  = T_L + T_H + (NBITS - 1) * 2 * T_H;
  localparam int          AUTO_P = CLK_HZ / 1000;

  logic       clock      = 1'b0;
  logic       reset_n    = 1'b1;
  logic       rst_auto_n = 1'b1;
  logic       i_poll     = 1'b0;
  logic       a_poll     = 1'b0;
  logic       joy_data, joy_strobe, joy_clock, o_valid, o_busy;
  logic [7:0] o_btn;
  logic       a_data, a_strobe, a_clock, a_valid, a_busy;
  logic [7:0] a_btn;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  nes_joypad_reader #(
    .C_clk_hz(CLK_HZ), .C_half_us(6), .C_latch_us(12),
    .C_poll_hz(60), .C_auto_poll(0), .C_num_bits(NBITS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .i_poll(i_poll), .joy_data(joy_data),
    .joy_strobe(joy_strobe), .joy_clock(joy_clock), .o_btn(o_btn),
    .o_valid(o_valid), .o_busy(o_busy)
  );

  nes_joypad_reader #(
    .C_clk_hz(CLK_HZ), .C_half_us(6), .C_latch_us(12),
    .C_poll_hz(1000), .C_auto_poll(1), .C_num_bits(NBITS)
  ) dut_auto (
    .clock(clock), .reset_n(rst_auto_n), .i_poll(a_poll), .joy_data(a_data),
    .joy_strobe(a_strobe), .joy_clock(a_clock), .o_btn(a_btn),
    .o_valid(a_valid), .o_busy(a_busy)
  );

  // 4021 pad model: parallel load while latch high, shift on clock rise, serial-in high
  logic [7:0] buttons = '0;
  logic       pad_en  = 1'b1;
  logic       glitch  = 1'b0;
  logic [7:0] pad_sr  = '1;
  always @(posedge joy_strobe or posedge joy_clock)
    if (joy_strobe) pad_sr <= ~buttons;
    else            pad_sr <= {1'b1, pad_sr[7:1]};
  assign joy_data = (pad_en ? pad_sr[0] : 1'b1) ^ glitch;

  logic [7:0] a_buttons = '0;
  logic [7:0] a_sr      = '1;
  always @(posedge a_strobe or posedge a_clock)
    if (a_strobe) a_sr <= ~a_buttons;
    else          a_sr <= {1'b1, a_sr[7:1]};
  assign a_data = a_sr[0];

  // Scoreboard monitor for the on-demand instance
  logic [7:0] exp_q[$];
  int         valid_cyc_q[$];
  int         valid_cnt = 0;
  int         hold_viol = 0;
  logic [7:0] held      = '0;
  logic [7:0] sb_exp;
  always @(negedge clock) begin
    if (!reset_n) begin
      held = '0;
    end else if (o_valid) begin
      valid_cnt++;
      valid_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid: got o_btn=%h with no frame expected", o_btn);
      end else begin
        sb_exp = exp_q.pop_front();
        if (o_btn !== sb_exp) begin
          errors++;
          $display("FAIL sb_btn: got %h required %h", o_btn, sb_exp);
        end
      end
      held = o_btn;
    end else if (o_btn !== held) begin
      hold_viol++;
    end
  end

  // Monitor for the auto-polling instance
  int         a_cnt       = 0;
  int         a_last      = 0;
  int         a_hold_viol = 0;
  logic [7:0] a_held      = '0;
  always @(negedge clock) begin
    if (rst_auto_n) begin
      if (a_valid) begin
        if (a_cnt > 0 && a_cnt <= 5) begin
          checks++;
          if (cyc - a_last != AUTO_P) begin
            errors++;
            $display("FAIL auto_spacing: got %0d cycles required %0d", cyc - a_last, AUTO_P);
          end
        end
        if (a_cnt < 6) begin
          checks++;
          if (a_btn !== a_buttons) begin
            errors++;
            $display("FAIL auto_btn: got %h required %h", a_btn, a_buttons);
          end
        end
        a_cnt++;
        a_last = cyc;
        a_held = a_btn;
      end else if (a_btn !== a_held) begin
        a_hold_viol++;
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame();
    @(negedge clock);
    i_poll = 1'b1;
    @(posedge clock);
    #1;
    i_poll = 1'b0;
  endtask

  task automatic wait_level(input logic lvl);
    int n;
    n = 0;
    while (joy_clock !== lvl && n < 400) begin
      tick();
      n++;
    end
    if (joy_clock !== lvl) begin
      checks++;
      errors++;
      $display("FAIL timeout_joy_clock: got %b required %b", joy_clock, lvl);
    end
  endtask

  task automatic wait_valid(input int target);
    int n;
    n = 0;
    while (valid_cnt < target && n < 600) begin
      tick();
      n++;
    end
    if (valid_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL timeout_valid: got %0d frames required %0d", valid_cnt, target);
    end
  endtask

  initial begin
    int s_first, s_last, pulses, bad_hi, bad_lo, first_rise, v_at, run;
    int busy_v, busy_n, base, k, qs;
    logic prev_clk;
    logic [7:0] b;

    a_buttons = 8'($urandom);
    #1;
    reset_n    = 1'b0;
    rst_auto_n = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("reset_strobe", int'(joy_strobe), 0);
    check("reset_clock",  int'(joy_clock), 0);
    check("reset_busy",   int'(o_busy), 0);
    check("reset_valid",  int'(o_valid), 0);
    check("reset_btn",    int'(o_btn), 0);
    @(negedge clock);
    reset_n    = 1'b1;
    rst_auto_n = 1'b1;
    tick();
    tick();

    // Frame 1: A, Start, Right with full waveform timing
    buttons = 8'((1 << BTN_A) | (1 << BTN_START) | (1 << BTN_RIGHT));
    exp_q.push_back(8'b1000_1001);
    start_frame();
    s_first = 0; s_last = 0; pulses = 0; bad_hi = 0; bad_lo = 0;
    first_rise = 0; v_at = 0; run = 0; busy_v = 0; busy_n = 1; prev_clk = 1'b0;
    for (int c = 1; c <= FRAME + 8; c++) begin
      @(negedge clock);
      if (joy_strobe) begin
        if (s_first == 0) s_first = c;
        s_last = c;
      end
      if (joy_clock !== prev_clk) begin
        if (joy_clock) begin
          pulses++;
          if (first_rise == 0) first_rise = c;
          else if (run != T_H) bad_lo++;
        end else if (run != T_H) begin
          bad_hi++;
        end
        run = 0;
      end
      run++;
      prev_clk = joy_clock;
      if (o_valid && v_at == 0) v_at = c;
      if (c == FRAME + 1) busy_v = int'(o_busy);
      if (c == FRAME + 2) busy_n = int'(o_busy);
    end
    check("strobe_first", s_first, 1);
    check("strobe_last", s_last, T_L);
    check("clock_pulses", pulses, NBITS - 1);
    check("first_rise", first_rise, T_L + T_H + 1);
    check("bad_high_runs", bad_hi, 0);
    check("bad_low_runs", bad_lo, 0);
    check("valid_cycle", v_at, FRAME + 1);
    check("busy_in_done", busy_v, 1);
    check("busy_after_done", busy_n, 0);

    // All released, all pressed, disconnected pad
    buttons = 8'h00; exp_q.push_back(8'h00); start_frame(); wait_valid(2);
    buttons = 8'hFF; exp_q.push_back(8'hFF); start_frame(); wait_valid(3);
    pad_en = 1'b0; buttons = 8'hFF; exp_q.push_back(8'h00); start_frame(); wait_valid(4);
    pad_en = 1'b1;

    // Random button patterns
    for (int i = 0; i < 6; i++) begin
      buttons = 8'($urandom);
      exp_q.push_back(buttons);
      base = valid_cnt;
      start_frame();
      wait_valid(base + 1);
    end

    // Two requests while busy collapse into one pending frame
    buttons = 8'($urandom);
    exp_q.push_back(buttons);
    exp_q.push_back(buttons);
    base = valid_cnt;
    start_frame();
    repeat (20) tick();
    start_frame();
    repeat (10) tick();
    start_frame();
    wait_valid(base + 2);
    qs = valid_cyc_q.size();
    if (qs >= 2) check("pending_gap", valid_cyc_q[qs-1] - valid_cyc_q[qs-2], FRAME + 2);
    repeat (300) tick();
    check("pending_frames", valid_cnt - base, 2);

    // Asynchronous reset in mid-frame
    buttons = 8'($urandom) | 8'h01;
    base = valid_cnt;
    start_frame();
    repeat (49) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_strobe", int'(joy_strobe), 0);
    check("midreset_clock", int'(joy_clock), 0);
    check("midreset_busy", int'(o_busy), 0);
    check("midreset_btn", int'(o_btn), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (150) tick();
    check("midreset_no_valid", valid_cnt - base, 0);
    check("midreset_btn_hold", int'(o_btn), 0);
    exp_q.push_back(buttons);
    start_frame();
    wait_valid(base + 1);

    // Data toggles during clock-high phases, away from any sample point
    buttons = 8'($urandom);
    exp_q.push_back(buttons);
    base = valid_cnt;
    start_frame();
    for (int p = 1; p < NBITS; p++) begin
      wait_level(1'b1);
      @(posedge clock); #3 glitch = 1'b1;
      @(posedge clock); #3 glitch = 1'b0;
      wait_level(1'b0);
    end
    wait_valid(base + 1);

    // Data inverted across the sample point of one bit
    k = int'($urandom_range(1, NBITS - 1));
    buttons = 8'($urandom);
    b = buttons ^ (8'd1 << k);
    exp_q.push_back(b);
    base = valid_cnt;
    start_frame();
    for (int p = 1; p <= k; p++) begin
      wait_level(1'b1);
      wait_level(1'b0);
    end
    tick();
    tick();
    #1 glitch = 1'b1;
    repeat (4) tick();
    #1 glitch = 1'b0;
    wait_valid(base + 1);

    // Let the auto-polling instance complete enough frames
    for (int n = 0; n < 8000 && a_cnt < 6; n++) tick();
    check("auto_frames", (a_cnt >= 6) ? 1 : 0, 1);
    check("auto_btn_stable", a_hold_viol, 0);
    check("btn_stable", hold_viol, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
